tmds_encoder_pipe: RTL

Parametrised, pipelined multi-channel TMDS encoder for the DVI/HDMI transmit path. It sits between the video timing/packet mux and the 10:1 serialisers, with one lane per TMDS channel. Each lane supports four modes:

- DVI 1.0 8b/10b video encoding with a running disparity counter per lane
- 2b/10b control encoding
- HDMI TERC4 data-island encoding
- Video guard-band insertion

All lanes share a fixed 2-cycle pipeline with a common clock enable.

---
 rtl/tmds_encoder_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_pipe.sv
// Multi-lane TMDS encoder: DVI 8b/10b video, 2b/10b control, TERC4 and guard band,
// behind a two-stage pipeline that advances only when ce is high.
module tmds_encoder_pipe #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic [8*NUM_CH-1:0]      din,
    input  logic [2*NUM_CH-1:0]      ctrl,
    input  logic [4*NUM_CH-1:0]      terc,
    output logic [10*NUM_CH-1:0]     dout,
    output logic [CNT_W*NUM_CH-1:0]  disp
);

    localparam logic [1:0] MODE_CTRL  = 2'b00;
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_TERC  = 2'b10;
    localparam logic [1:0] MODE_GUARD = 2'b11;

    localparam logic [9:0] CTRL_IDLE = 10'b1101010100;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: XNOR chain for byte values that are ones-heavy.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00: s = 10'b1101010100;
            2'b01: s = 10'b0010101011;
            2'b10: s = 10'b0101010100;
            2'b11: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc_code(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            4'hF: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Mode travels with the data so a switch lands on exactly the symbol it came with.
    logic [1:0] mode_s1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_reg <= MODE_CTRL;
        end else if (ce) begin
            mode_s1_reg <= mode;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            localparam logic [9:0] GUARD_SYM = (gi % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
            localparam logic signed [CNT_W-1:0] ZERO  = '0;
            localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
            localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

            logic [7:0]              din_lane;
            logic [8:0]              qm_next;
            logic [8:0]              qm_reg;
            logic [3:0]              n1q_reg;
            logic [1:0]              ctrl_reg;
            logic [3:0]              terc_reg;
            logic signed [CNT_W-1:0] n1q_s;
            logic signed [CNT_W-1:0] bal;
            logic                    cnt_pos;
            logic                    cnt_neg;
            logic signed [CNT_W-1:0] cnt_reg;
            logic signed [CNT_W-1:0] cnt_next;
            logic [9:0]              sym_reg;
            logic [9:0]              sym_next;

            assign din_lane = din[8*gi +: 8];
            assign qm_next  = qm_encode(din_lane);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qm_reg   <= '0;
                    n1q_reg  <= '0;
                    ctrl_reg <= '0;
                    terc_reg <= '0;
                end else if (ce) begin
                    qm_reg   <= qm_next;
                    n1q_reg  <= ones8(qm_next[7:0]);
                    ctrl_reg <= ctrl[2*gi +: 2];
                    terc_reg <= terc[4*gi +: 4];
                end
            end

            // bal = N1q - N0q = 2*N1q - 8
            assign n1q_s   = signed'({{(CNT_W-4){1'b0}}, n1q_reg});
            assign bal     = n1q_s + n1q_s - EIGHT;
            assign cnt_neg = cnt_reg[CNT_W-1];
            assign cnt_pos = !cnt_reg[CNT_W-1] && (cnt_reg != ZERO);

            always_comb begin
                sym_next = CTRL_IDLE;
                cnt_next = ZERO;
                case (mode_s1_reg)
                    MODE_VIDEO: begin
                        if ((cnt_reg == ZERO) || (n1q_reg == 4'd4)) begin
                            sym_next = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
                            cnt_next = qm_reg[8] ? (cnt_reg + bal) : (cnt_reg - bal);
                        end else if ((cnt_pos && (n1q_reg > 4'd4)) || (cnt_neg && (n1q_reg < 4'd4))) begin
                            sym_next = {1'b1, qm_reg[8], ~qm_reg[7:0]};
                            cnt_next = cnt_reg + (qm_reg[8] ? TWO : ZERO) - bal;
                        end else begin
                            sym_next = {1'b0, qm_reg[8], qm_reg[7:0]};
                            cnt_next = cnt_reg - (qm_reg[8] ? ZERO : TWO) + bal;
                        end
                    end
                    MODE_TERC: begin
                        sym_next = terc_code(terc_reg);
                    end
                    MODE_GUARD: begin
                        sym_next = GUARD_SYM;
                    end
                    default: begin
                        sym_next = ctrl_code(ctrl_reg);
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sym_reg <= CTRL_IDLE;
                    cnt_reg <= ZERO;
                end else if (ce) begin
                    sym_reg <= sym_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign dout[10*gi +: 10]      = sym_reg;
            assign disp[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate

endmodule
